crop_norm_mono8: RTL

// - Downstream of the Mono8 sequentializer: takes one 8-bit pixel per handshake plus its (cnt_col, cnt_row) frame coordinates.
// - Keeps only an OUT_ROWS x OUT_COLS window of the IN_ROWS x IN_COLS frame and drops everything else.
// - Normalizes kept pixels to signed fixed point: ((pix - NORM_OFFSET) * NORM_SCALE) >>> NORM_SHIFT, saturated.
// - Streams the result to the hls4ml input; its ap_ready drives the sequentializer's cn_ap_ready.

---
 rtl/crop_norm_mono8.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/crop_norm_mono8.sv
// Crops an OUT_ROWS x OUT_COLS window from a Mono8 pixel stream and normalizes it to saturated signed fixed point.
// Optional feature macro: CROP_NORM_TLAST_EN adds m_axis_tlast marking the last pixel of the window.
module crop_norm_mono8 #(
  parameter int IN_ROWS     = 20,
  parameter int IN_COLS     = 20,
  parameter int CROP_Y0     = 2,
  parameter int CROP_X0     = 2,
  parameter int OUT_ROWS    = 16,
  parameter int OUT_COLS    = 16,
  parameter int NORM_OFFSET = 0,
  parameter int NORM_SCALE  = 1,
  parameter int NORM_SHIFT  = 0,
  parameter int OUT_WIDTH   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ap_start,
  output logic                          ap_ready,
  output logic                          ap_idle,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic [7:0]                    s_axis_tdata,
  input  logic [$clog2(IN_COLS)-1:0]    cnt_col,
  input  logic [$clog2(IN_ROWS)-1:0]    cnt_row,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic signed [OUT_WIDTH-1:0]   m_axis_tdata
`ifdef CROP_NORM_TLAST_EN
  ,
  output logic                          m_axis_tlast
`endif
);

  localparam logic [8:0]        OFFSET9 = 9'(NORM_OFFSET);
  localparam logic signed [8:0] SCALE9  = 9'(NORM_SCALE);
  localparam int                SAT_MAX = (1 <<< (OUT_WIDTH - 1)) - 1;
  localparam int                SAT_MIN = -(1 <<< (OUT_WIDTH - 1));

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FLUSH, ST_DONE} state_t;

  state_t state_q, state_d;

  logic                        s1_valid_q, s1_keep_q;
  logic signed [8:0]           s1_diff_q;
  logic                        s2_valid_q, s2_keep_q;
  logic signed [OUT_WIDTH-1:0] tdata_q;

  logic                        adv;
  logic                        accept;
  logic                        in_keep;
  logic                        in_last;
  logic [31:0]                 row_w, col_w;
  logic signed [8:0]           diff_w;
  logic signed [17:0]          prod_w;
  logic signed [17:0]          res_w;
  int                          res_i;
  logic signed [OUT_WIDTH-1:0] sat_w;

  // The whole pipeline moves as one unit whenever the output slot is free or being drained.
  assign adv    = !m_axis_tvalid || m_axis_tready;
  assign accept = s_axis_tvalid && s_axis_tready;

  assign row_w   = 32'(cnt_row);
  assign col_w   = 32'(cnt_col);
  assign in_keep = (row_w >= 32'(CROP_Y0)) && (row_w < 32'(CROP_Y0 + OUT_ROWS)) &&
                   (col_w >= 32'(CROP_X0)) && (col_w < 32'(CROP_X0 + OUT_COLS));
  assign in_last = (row_w == 32'(IN_ROWS - 1)) && (col_w == 32'(IN_COLS - 1));
  assign diff_w  = $signed({1'b0, s_axis_tdata} - OFFSET9);

  assign prod_w = 18'(s1_diff_q) * 18'(SCALE9);
  assign res_w  = prod_w >>> NORM_SHIFT;
  assign res_i  = 32'(res_w);

  always_comb begin
    sat_w = OUT_WIDTH'(res_i);
    if (res_i > SAT_MAX) begin
      sat_w = OUT_WIDTH'(SAT_MAX);
    end else if (res_i < SAT_MIN) begin
      sat_w = OUT_WIDTH'(SAT_MIN);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    ap_idle       = 1'b0;
    ap_ready      = 1'b0;
    s_axis_tready = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        ap_idle  = 1'b1;
        ap_ready = 1'b1;
        if (ap_start) state_d = ST_RUN;
      end
      ST_RUN: begin
        s_axis_tready = adv;
        if (s_axis_tvalid && adv && in_last) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (!s1_valid_q && !s2_valid_q) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s1_keep_q  <= 1'b0;
      s1_diff_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_keep_q  <= 1'b0;
      tdata_q    <= '0;
    end else if (adv) begin
      s1_valid_q <= accept;
      s1_keep_q  <= in_keep;
      s1_diff_q  <= diff_w;
      s2_valid_q <= s1_valid_q;
      s2_keep_q  <= s1_keep_q;
      tdata_q    <= sat_w;
    end
  end

  assign m_axis_tvalid = s2_valid_q && s2_keep_q;
  assign m_axis_tdata  = tdata_q;

`ifdef CROP_NORM_TLAST_EN
  logic in_tlast;
  logic s1_last_q, s2_last_q;

  assign in_tlast = (row_w == 32'(CROP_Y0 + OUT_ROWS - 1)) && (col_w == 32'(CROP_X0 + OUT_COLS - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_last_q <= 1'b0;
      s2_last_q <= 1'b0;
    end else if (adv) begin
      s1_last_q <= accept && in_tlast;
      s2_last_q <= s1_last_q;
    end
  end

  assign m_axis_tlast = s2_last_q;
`endif

endmodule
